// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: operating mode, atan table entries,
// reciprocal gain constant and a width-parametrised saturation helper.
package cordic_pkg;

   typedef enum logic {
      CORDIC_ROT = 1'b0,
      CORDIC_VEC = 1'b1
   } cordic_mode_e;

   localparam real CORDIC_PI = 3.14159265358979323846;

   // atan(2^-i) scaled so that 2^phi_wdt is a full turn, rounded to nearest
   function automatic int atan_lut(input int phi_wdt, input int i);
      real a;
      a = $atan(1.0 / (2.0 ** i)) / (2.0 * CORDIC_PI) * (2.0 ** phi_wdt);
      return $rtoi(a + 0.5);
   endfunction

   // 1/K for n micro-rotations with frac fractional bits, rounded to nearest
   function automatic int inv_gain(input int n, input int frac);
      real k;
      k = 1.0;
      for (int i = 0; i < n; i++) k = k * $sqrt(1.0 + 2.0 ** (-2 * i));
      return $rtoi((2.0 ** frac) / k + 0.5);
   endfunction

   // clamp a signed value into the range of a w-bit two's complement number
   function automatic longint sat(input longint v, input int w);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (w - 1)) - 1;
      lo = -(longint'(1) <<< (w - 1));
      if (v > hi) return hi;
      if (v < lo) return lo;
      return v;
   endfunction

endpackage

// File: rtl/cordic_stage.sv
// One registered CORDIC micro-rotation with shift index SHIFT.
// Valid, mode and tag ride along with the data; everything moves on adv.
module cordic_stage
   import cordic_pkg::*;
#(
   parameter int XW      = 18,
   parameter int PHI_WDT = 18,
   parameter int TAG_WDT = 4,
   parameter int SHIFT   = 0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr,
   input  logic                adv,
   input  logic                in_vld,
   input  cordic_mode_e        in_mode,
   input  logic signed [XW-1:0] in_x,
   input  logic signed [XW-1:0] in_y,
   input  logic [PHI_WDT-1:0]  in_z,
   input  logic [TAG_WDT-1:0]  in_tag,
   output logic                out_vld,
   output cordic_mode_e        out_mode,
   output logic signed [XW-1:0] out_x,
   output logic signed [XW-1:0] out_y,
   output logic [PHI_WDT-1:0]  out_z,
   output logic [TAG_WDT-1:0]  out_tag
);

   localparam logic [PHI_WDT-1:0] ATAN_C = PHI_WDT'(atan_lut(PHI_WDT, SHIFT));

   logic signed [XW-1:0] xs, ys;
   logic                 d_pos;

   assign xs = in_x >>> SHIFT;
   assign ys = in_y >>> SHIFT;
   // rotation drives z toward 0, vectoring drives y toward 0
   assign d_pos = (in_mode == CORDIC_VEC) ? in_y[XW-1] : ~in_z[PHI_WDT-1];

   // micro-rotation register; clear beats advance
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_vld  <= 1'b0;
         out_mode <= CORDIC_ROT;
         out_x    <= '0;
         out_y    <= '0;
         out_z    <= '0;
         out_tag  <= '0;
      end else if (clr) begin
         out_vld  <= 1'b0;
         out_mode <= CORDIC_ROT;
         out_x    <= '0;
         out_y    <= '0;
         out_z    <= '0;
         out_tag  <= '0;
      end else if (adv) begin
         out_vld  <= in_vld;
         out_mode <= in_mode;
         out_x    <= d_pos ? in_x - ys : in_x + ys;
         out_y    <= d_pos ? in_y + xs : in_y - xs;
         out_z    <= d_pos ? in_z - ATAN_C : in_z + ATAN_C;
         out_tag  <= in_tag;
      end
   end

endmodule

// File: rtl/cordic_rot_vec_pipe.sv
// Pipelined CORDIC, rotation or vectoring selectable per sample.
// Pipe: pre-rotation register, N micro-rotation stages, gain/saturate register.
// Define CORDIC_GAIN_COMP_EN to scale results by 1/K in the last stage;
// otherwise that stage only saturates and results carry the CORDIC gain K.
module cordic_rot_vec_pipe
   import cordic_pkg::*;
#(
   parameter int N        = 16,
   parameter int DATA_WDT = 16,
   parameter int PHI_WDT  = 18,
   parameter int TAG_WDT  = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       sclr,
   input  logic                       en,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic                       in_mode,
   input  logic signed [DATA_WDT-1:0] in_x,
   input  logic signed [DATA_WDT-1:0] in_y,
   input  logic [PHI_WDT-1:0]         in_phi,
   input  logic [TAG_WDT-1:0]         in_tag,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic signed [DATA_WDT-1:0] out_x,
   output logic signed [DATA_WDT-1:0] out_y,
   output logic [PHI_WDT-1:0]         out_phi,
   output logic [TAG_WDT-1:0]         out_tag
);

   // two guard bits cover gain K (~1.647) times sqrt(2)
   localparam int XW = DATA_WDT + 2;
   localparam int RW = XW + DATA_WDT + 2;
   localparam logic [PHI_WDT-1:0] PHI_PI = {1'b1, {(PHI_WDT-1){1'b0}}};

   logic adv, clr;
   logic [N+1:0]             vld_pipe;
   cordic_mode_e             mode_pipe [N:0];
   logic [N:0][XW-1:0]       x_pipe, y_pipe;
   logic [N:0][PHI_WDT-1:0]  z_pipe;
   logic [N:0][TAG_WDT-1:0]  tag_pipe;

   assign adv      = en & (~out_valid | out_ready);
   assign clr      = en & sclr;
   assign in_ready = adv;

   // ---------------- pre-rotation ----------------
   cordic_mode_e         in_mode_e;
   logic [1:0]           phi_top;
   logic                 pre_flip;
   logic signed [XW-1:0] xe, ye, pre_xn, pre_yn;
   logic [PHI_WDT-1:0]   pre_zn;

   logic                 pre_vld;
   cordic_mode_e         pre_mode;
   logic signed [XW-1:0] pre_x, pre_y;
   logic [PHI_WDT-1:0]   pre_z;
   logic [TAG_WDT-1:0]   pre_tag;

   assign in_mode_e = cordic_mode_e'(in_mode);
   assign phi_top   = in_phi[PHI_WDT-1 -: 2];
   assign xe        = {{2{in_x[DATA_WDT-1]}}, in_x};
   assign ye        = {{2{in_y[DATA_WDT-1]}}, in_y};

   // fold the input into the +-90 degree convergence range by a pi rotation
   always_comb begin
      pre_flip = 1'b0;
      pre_zn   = in_phi;
      if (in_mode_e == CORDIC_VEC) begin
         pre_flip = in_x[DATA_WDT-1];
         pre_zn   = pre_flip ? PHI_PI : '0;
      end else begin
         pre_flip = (phi_top == 2'b01) || (phi_top == 2'b10);
         pre_zn   = pre_flip ? in_phi + PHI_PI : in_phi;
      end
      pre_xn = pre_flip ? -xe : xe;
      pre_yn = pre_flip ? -ye : ye;
   end

   // pre-rotation register; sclr drops a simultaneous handshake
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_vld  <= 1'b0;
         pre_mode <= CORDIC_ROT;
         pre_x    <= '0;
         pre_y    <= '0;
         pre_z    <= '0;
         pre_tag  <= '0;
      end else if (clr) begin
         pre_vld  <= 1'b0;
         pre_mode <= CORDIC_ROT;
         pre_x    <= '0;
         pre_y    <= '0;
         pre_z    <= '0;
         pre_tag  <= '0;
      end else if (adv) begin
         pre_vld  <= in_valid;
         pre_mode <= in_mode_e;
         pre_x    <= pre_xn;
         pre_y    <= pre_yn;
         pre_z    <= pre_zn;
         pre_tag  <= in_tag;
      end
   end

   assign vld_pipe[0]  = pre_vld;
   assign mode_pipe[0] = pre_mode;
   assign x_pipe[0]    = pre_x;
   assign y_pipe[0]    = pre_y;
   assign z_pipe[0]    = pre_z;
   assign tag_pipe[0]  = pre_tag;

   // ---------------- micro-rotations ----------------
   for (genvar i = 0; i < N; i++) begin : g_stage
      cordic_stage #(
         .XW(XW), .PHI_WDT(PHI_WDT), .TAG_WDT(TAG_WDT), .SHIFT(i)
      ) u_stage (
         .clk(clk), .reset(reset), .clr(clr), .adv(adv),
         .in_vld(vld_pipe[i]), .in_mode(mode_pipe[i]),
         .in_x(x_pipe[i]), .in_y(y_pipe[i]), .in_z(z_pipe[i]), .in_tag(tag_pipe[i]),
         .out_vld(vld_pipe[i+1]), .out_mode(mode_pipe[i+1]),
         .out_x(x_pipe[i+1]), .out_y(y_pipe[i+1]), .out_z(z_pipe[i+1]),
         .out_tag(tag_pipe[i+1])
      );
   end

   // mode is not needed past the last micro-rotation
   logic unused_mode;
   assign unused_mode = (mode_pipe[N] == CORDIC_VEC);

   // ---------------- gain / saturate ----------------
   logic signed [XW-1:0] xn, yn;
   logic signed [RW-1:0] xr, yr;

   assign xn = x_pipe[N];
   assign yn = y_pipe[N];

`ifdef CORDIC_GAIN_COMP_EN
   // 1/K with DATA_WDT+1 fraction bits, fits DATA_WDT+2 bits since 1/K < 1
   localparam logic signed [RW-1:0] KINV = RW'(inv_gain(N, DATA_WDT + 1));
   localparam logic signed [RW-1:0] RND  = RW'(longint'(1) <<< DATA_WDT);
   logic signed [RW-1:0] xw, yw;
   assign xw = RW'(xn);
   assign yw = RW'(yn);
   assign xr = (xw * KINV + RND) >>> (DATA_WDT + 1);
   assign yr = (yw * KINV + RND) >>> (DATA_WDT + 1);
`else
   assign xr = RW'(xn);
   assign yr = RW'(yn);
`endif

   // output register; results clamp instead of wrapping
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_phi   <= '0;
         out_tag   <= '0;
      end else if (clr) begin
         out_valid <= 1'b0;
         out_x     <= '0;
         out_y     <= '0;
         out_phi   <= '0;
         out_tag   <= '0;
      end else if (adv) begin
         out_valid <= vld_pipe[N];
         out_x     <= DATA_WDT'(sat(longint'(xr), DATA_WDT));
         out_y     <= DATA_WDT'(sat(longint'(yr), DATA_WDT));
         out_phi   <= z_pipe[N];
         out_tag   <= tag_pipe[N];
      end
   end

   assign vld_pipe[N+1] = out_valid;

endmodule

// File: tb/tb_cordic_rot_vec_pipe.sv
// Directed bench for cordic_rot_vec_pipe: reset, test-plan vectors, a stalled
// mixed-mode stream against a bit-exact algorithm model, sclr and reset flush.
module tb_cordic_rot_vec_pipe;
   localparam int N   = 16;
   localparam int DW  = 16;
   localparam int PW  = 18;
   localparam int TW  = 4;
   localparam int LAT = N + 2;
   localparam longint PM = longint'(1) << PW;
   localparam real PI = 3.14159265358979323846;
`ifdef CORDIC_GAIN_COMP_EN
   localparam bit COMP = 1'b1;
`else
   localparam bit COMP = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset, sclr, en, in_valid, in_ready, in_mode, out_valid, out_ready;
   logic signed [DW-1:0] in_x, in_y, out_x, out_y;
   logic [PW-1:0] in_phi, out_phi;
   logic [TW-1:0] in_tag, out_tag;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cordic_rot_vec_pipe #(.N(N), .DATA_WDT(DW), .PHI_WDT(PW), .TAG_WDT(TW)) dut (
      .clk(clk), .reset(reset), .sclr(sclr), .en(en),
      .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
      .in_x(in_x), .in_y(in_y), .in_phi(in_phi), .in_tag(in_tag),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_phi(out_phi), .out_tag(out_tag)
   );

   typedef struct {
      logic signed [DW-1:0] x;
      logic signed [DW-1:0] y;
      logic [PW-1:0]        phi;
      logic [TW-1:0]        tag;
   } res_t;

   longint atan_t [N];
   longint kinv;
   real    kgain;
   res_t   expq [$];

   task automatic chk(input string tag, input longint got, input longint exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic chk_near(input string tag, input longint got, input longint exp,
                           input longint tol, input bit is_phi);
      longint d;
      bit ok;
      d = got - exp;
      if (is_phi) begin
         d = d & (PM - 1);
         if (d >= PM / 2) d = d - PM;
      end
      ok = (d <= tol) && (d >= -tol);
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s got %0d expected %0d +-%0d", tag, got, exp, tol);
      end
   endtask

   // straightforward algorithmic reference of the documented CORDIC behaviour
   function automatic res_t model(input logic m, input logic signed [DW-1:0] x,
                                  input logic signed [DW-1:0] y,
                                  input logic [PW-1:0] phi, input logic [TW-1:0] tag);
      longint xx, yy, zz, xs, ys, lim;
      res_t r;
      xx = longint'(x);
      yy = longint'(y);
      zz = longint'(phi);
      if (m) begin
         if (xx < 0) begin xx = -xx; yy = -yy; zz = PM / 2; end
         else zz = 0;
      end else if (zz >= PM / 4 && zz < 3 * PM / 4) begin
         xx = -xx; yy = -yy; zz = (zz + PM / 2) % PM;
      end
      for (int i = 0; i < N; i++) begin
         xs = xx >>> i;
         ys = yy >>> i;
         if (m ? (yy < 0) : (zz < PM / 2)) begin
            xx = xx - ys; yy = yy + xs; zz = (zz - atan_t[i] + PM) % PM;
         end else begin
            xx = xx + ys; yy = yy - xs; zz = (zz + atan_t[i]) % PM;
         end
      end
      if (COMP) begin
         xx = (xx * kinv + (longint'(1) << DW)) >>> (DW + 1);
         yy = (yy * kinv + (longint'(1) << DW)) >>> (DW + 1);
      end
      lim = longint'(1) << (DW - 1);
      if (xx > lim - 1) xx = lim - 1;
      if (xx < -lim) xx = -lim;
      if (yy > lim - 1) yy = lim - 1;
      if (yy < -lim) yy = -lim;
      r.x = DW'(xx);
      r.y = DW'(yy);
      r.phi = PW'(zz);
      r.tag = tag;
      return r;
   endfunction

   // drive one sample right after a falling edge, wait (bounded) for its result
   task automatic send_one(input logic m, input longint x, input longint y,
                           input longint phi, input longint tag,
                           output res_t r, output int lat);
      in_valid = 1'b1; in_mode = m;
      in_x = DW'(x); in_y = DW'(y); in_phi = PW'(phi); in_tag = TW'(tag);
      @(negedge clk);
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 60) begin
         @(negedge clk);
         lat++;
      end
      r.x = out_x; r.y = out_y; r.phi = out_phi; r.tag = out_tag;
   endtask

   task automatic fill(input int cnt);
      for (int k = 0; k < cnt; k++) begin
         in_valid = 1'b1; in_mode = k[0];
         in_x = DW'(1000 * k - 9000); in_y = DW'(700 * k + 50);
         in_phi = PW'(9001 * k); in_tag = TW'(k);
         @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   logic                 sm   [64];
   logic signed [DW-1:0] sx   [64];
   logic signed [DW-1:0] sy   [64];
   logic [PW-1:0]        sphi [64];
   res_t r, e;
   int   lat, idx, cyc, nout, nv;
   real  gain;
   longint tol, mag;

   initial begin
      reset = 1'b1; sclr = 1'b0; en = 1'b1; in_valid = 1'b0; in_mode = 1'b0;
      in_x = '0; in_y = '0; in_phi = '0; in_tag = '0; out_ready = 1'b1;

      kgain = 1.0;
      for (int i = 0; i < N; i++) begin
         atan_t[i] = longint'($rtoi($atan(1.0 / (2.0 ** i)) / (2.0 * PI) * (2.0 ** PW) + 0.5));
         kgain = kgain * $sqrt(1.0 + 2.0 ** (-2 * i));
      end
      kinv = longint'($rtoi((2.0 ** (DW + 1)) / kgain + 0.5));
      gain = COMP ? 1.0 : kgain;
      tol  = COMP ? 4 : 7;
      mag  = longint'($rtoi(16384.0 * gain + 0.5));

      for (int i = 0; i < 64; i++) begin
         sm[i] = 1'(($urandom >> 3) & 1);
         sx[i] = DW'($urandom);
         sy[i] = DW'($urandom);
         sphi[i] = PW'($urandom);
      end
      sm[3] = 1'b1; sx[3] = '0; sy[3] = '0;
      sm[5] = 1'b1; sx[5] = -16'sd32768; sy[5] = 16'sd100;

      // reset state
      repeat (3) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_x", out_x, 0);
      chk("rst_out_y", out_y, 0);
      chk("rst_out_phi", out_phi, 0);
      chk("rst_out_tag", out_tag, 0);
      reset = 1'b0;
      @(negedge clk);
      chk("idle_in_ready", in_ready, 1);

      // rotate (16384,0) by pi/2
      send_one(1'b0, 16384, 0, 'h10000, 5, r, lat);
      chk("rot90_latency", lat, LAT);
      chk_near("rot90_x", r.x, 0, tol, 1'b0);
      chk_near("rot90_y", r.y, mag, tol, 1'b0);
      chk("rot90_tag", r.tag, 5);
      @(negedge clk);

      // vectoring straight down
      send_one(1'b1, 0, -16384, 0, 9, r, lat);
      chk("vecdown_latency", lat, LAT);
      chk_near("vecdown_mag", r.x, mag, tol, 1'b0);
      chk_near("vecdown_phi", r.phi, 'h30000, 4, 1'b1);
      chk("vecdown_tag", r.tag, 9);
      @(negedge clk);

      // vectoring through the x<0 pre-rotation
      send_one(1'b1, -16384, 0, 0, 12, r, lat);
      chk_near("vecneg_mag", r.x, mag, tol, 1'b0);
      chk_near("vecneg_phi", r.phi, 'h20000, 4, 1'b1);
      chk("vecneg_tag", r.tag, 12);
      @(negedge clk);

      // saturating rotation of (32767,32767) by pi/4
      send_one(1'b0, 32767, 32767, 'h08000, 3, r, lat);
      chk_near("rotsat_x", r.x, 0, tol, 1'b0);
      chk("rotsat_y", r.y, 32767);
      @(negedge clk);

      // mixed stream with an output stall and clock-enable gaps
      idx = 0; cyc = 0; nout = 0;
      expq.delete();
      while ((idx < 64 || expq.size() != 0) && cyc < 400) begin
         en = !(cyc == 10 || cyc == 40 || cyc == 41);
         out_ready = !(cyc >= 25 && cyc < 30);
         in_valid = (idx < 64);
         if (idx < 64) begin
            in_mode = sm[idx]; in_x = sx[idx]; in_y = sy[idx];
            in_phi = sphi[idx]; in_tag = TW'(idx);
         end
         #1;
         if (cyc == 10 || cyc == 40) chk("en0_in_ready", in_ready, 0);
         if (cyc == 27) chk("stall_in_ready", in_ready, 0);
         if (out_valid && in_ready) begin
            chk("stream_nonempty", longint'(expq.size() > 0), 1);
            if (expq.size() > 0) begin
               e = expq.pop_front();
               chk("stream_x", out_x, e.x);
               chk("stream_y", out_y, e.y);
               chk("stream_phi", out_phi, e.phi);
               chk("stream_tag", out_tag, e.tag);
            end
            nout++;
         end
         if (in_valid && in_ready) begin
            expq.push_back(model(sm[idx], sx[idx], sy[idx], sphi[idx], TW'(idx)));
            idx++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0; en = 1'b1; out_ready = 1'b1;
      chk("stream_outputs", nout, 64);
      chk("stream_pending", expq.size(), 0);

      // synchronous clear with a full pipe
      fill(20);
      chk("prefill_valid", out_valid, 1);
      in_valid = 1'b1;
      sclr = 1'b1;
      @(negedge clk);
      sclr = 1'b0; in_valid = 1'b0;
      chk("sclr_out_valid", out_valid, 0);
      chk("sclr_out_x", out_x, 0);
      nv = 0;
      repeat (30) begin @(negedge clk); if (out_valid) nv++; end
      chk("sclr_no_stale", nv, 0);
      send_one(1'b0, 5000, -3000, 'h2F000, 7, r, lat);
      e = model(1'b0, 16'sd5000, -16'sd3000, 18'h2F000, 4'd7);
      chk("sclr_after_latency", lat, LAT);
      chk("sclr_after_x", r.x, e.x);
      chk("sclr_after_y", r.y, e.y);
      chk("sclr_after_phi", r.phi, e.phi);
      @(negedge clk);

      // asynchronous reset with a full pipe
      fill(20);
      chk("prefill2_valid", out_valid, 1);
      reset = 1'b1;
      #1;
      chk("areset_out_valid", out_valid, 0);
      chk("areset_out_tag", out_tag, 0);
      @(negedge clk);
      reset = 1'b0;
      nv = 0;
      repeat (30) begin @(negedge clk); if (out_valid) nv++; end
      chk("areset_no_stale", nv, 0);
      send_one(1'b1, -7000, 2500, 0, 14, r, lat);
      e = model(1'b1, -16'sd7000, 16'sd2500, 18'h0, 4'd14);
      chk("areset_after_latency", lat, LAT);
      chk("areset_after_x", r.x, e.x);
      chk("areset_after_phi", r.phi, e.phi);
      chk("areset_after_tag", r.tag, 14);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
